i2s_tx_module: RTL and testbench
================================

# i2s_tx_module

I2S master transmitter, the transmit-side counterpart of the I2S receiver core. Accepts stereo samples from the system side over a valid/ready handshake and buffers one pending frame. Derives `bck_o` and `lrck_o` from the system clock and serialises samples MSB-first in standard I2S format: one-BCK data delay after the LRCK edge, left slot while `lrck_o`=0. Drives an external codec/DAC or a loop-back into the receiver core.

## Interface
- `FRAME_RES`, 32: BCK periods per channel slot; a full frame is 2*`FRAME_RES` BCK periods.
- `DATA_RES`, 24: sample width. Must satisfy `DATA_RES` <= `FRAME_RES`-1.
- `BCK_DIV`, 4: `clk_i` cycles per BCK period. Even, >= 2.

Ports:
- `clk_i`  in  1: system clock. All logic is on its rising edge.
- `rst_i`  in  1: reset, asynchronous, active-low.
- `en_i`  in  1: run enable. Low forces idle.
- `left_i`  in  `DATA_RES`: left sample, two's complement.
- `right_i`  in  `DATA_RES`: right sample.
- `valid_i`  in  1: `left_i`/`right_i` hold a frame.
- `ready_o`  out  1: holding buffer empty. A frame transfers when `valid_i` & `ready_o`.
- `bck_o`  out  1: bit clock, 50% duty.
- `lrck_o`  out  1: word select; 0 = left slot, 1 = right slot.
- `dat_o`  out  1: serial data. Changes only with BCK falling edges.
- `underrun_o`  out  1: one-`clk_i` pulse when a frame starts with an empty buffer.

## Operation
- Reset values: `bck_o`=0, `lrck_o`=0, `dat_o`=0, `underrun_o`=0, `ready_o`=1; buffer empty; div_cnt=0; bit_cnt=2*`FRAME_RES`-1; shift register cleared.
- Divider: div_cnt counts 0..`BCK_DIV`/2-1. At terminal count it wraps and `bck_o` toggles. A toggle 1->0 is a "fall event" in that `clk_i` cycle.
- Fall event actions, in this order:
  - bit_cnt increments modulo 2*`FRAME_RES`.
  - `lrck_o` <= (new bit_cnt >= `FRAME_RES`).
  - `dat_o` <= shift register MSB, then the shift register shifts left, filling with 0.
- Frame start is the fall event where bit_cnt wraps to 0.
  - If the buffer is full: the shift register loads the 2*`FRAME_RES`-bit word {0, left, (`FRAME_RES`-1-`DATA_RES`) zeros, 0, right, zeros}, MSB first. The buffer empties.
  - If the buffer is empty: the shift register loads all zeros and `underrun_o` pulses.
  - In both cases the emitted `dat_o` for bit 0 is 0, the delay bit.
- Result: the left MSB appears at slot bit 1 and the right MSB at bit `FRAME_RES`+1. Unused trailing bits are 0.
- Buffer: one entry. `ready_o` = buffer empty. A handshake captures `left_i`/`right_i` and sets full.
- Handshake coinciding with a frame-start load that finds the buffer empty: counts as an underrun (no bypass). The captured frame goes out in the next frame.
- `en_i`=0: next cycle `bck_o`, `lrck_o`, `dat_o` return to 0 and div_cnt/bit_cnt/shift register return to reset values. The buffer and handshake keep operating.
- Re-enable restarts from the reset timing, so the first fall event is a frame start.
- `rst_i` asserted mid-frame: all state, including the buffer, clears immediately.

## Timing
- BCK period = `BCK_DIV` `clk_i` cycles: high for `BCK_DIV`/2, low for `BCK_DIV`/2.
- From reset release (or `en_i` rise) with `en_i`=1:
  - `bck_o` rises after `BCK_DIV`/2 cycles.
  - The first fall event is at cycle `BCK_DIV`; it is a frame start.
- `dat_o` and `lrck_o` update on the same `clk_i` edge as `bck_o` falls. They are stable across the following BCK rising edge, where the receiver samples.
- Sample latency: a handshake accepted while the buffer is empty reaches the wire at the next frame start. Its left MSB appears one BCK later.
- Throughput: one frame per 2*`FRAME_RES`*`BCK_DIV` `clk_i` cycles. `ready_o` reasserts in the cycle after a frame-start load.

## Test plan
- Defaults; left=0xABCDEF, right=0x123456 presented before the first frame start -> first fall at cycle 4, `dat_o`=0 then 101010111100110111101111 in bits 1..24, 0 in bits 25..32, `lrck_o` rises at bit 32. Right bits 33..56 = 0x123456 MSB first. No underrun.
- No `valid_i` after reset -> all `dat_o` 0; `underrun_o` pulses once per frame (every 256 `clk_i` cycles) on the wrap fall event.
- `valid_i` held high continuously with an incrementing counter -> exactly one accept per frame. Consecutive frames carry consecutive values; no underrun after the first frame.
- `valid_i` asserted in the same cycle as a frame-start fall with the buffer empty -> `underrun_o` pulses, zeros frame is sent, the captured sample appears in the next frame.
- `en_i` dropped at bit 10 of the left slot -> next cycle `bck_o`=`lrck_o`=`dat_o`=0. On re-enable, the first fall is 4 cycles later and is a frame start.
- `rst_i` asserted mid-right-slot with the buffer full -> outputs and buffer clear asynchronously, `ready_o`=1.

Source files
------------

// File: rtl/i2s_tx_module.sv
// I2S master transmitter: one-frame holding buffer, BCK/LRCK generation and
// MSB-first serialisation with the standard one-BCK data delay.
module i2s_tx_module #(
  parameter int FRAME_RES = 32,
  parameter int DATA_RES  = 24,
  parameter int BCK_DIV   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DATA_RES-1:0] left_i,
  input  logic [DATA_RES-1:0] right_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                bck_o,
  output logic                lrck_o,
  output logic                dat_o,
  output logic                underrun_o
);

  localparam int HALF  = BCK_DIV / 2;
  localparam int FW    = 2 * FRAME_RES;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(FW);

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_bck;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_lrck;
  logic                r_dat;
  logic [FW-1:0]       r_shift;
  logic                r_underrun;
  logic                r_buf_full;
  logic [DATA_RES-1:0] r_buf_left;
  logic [DATA_RES-1:0] r_buf_right;

  logic                w_div_tc;
  logic                w_fall;
  logic [BIT_W-1:0]    w_next_bit;
  logic                w_frame_start;
  logic [FW-1:0]       w_load_word;
  logic [FW-1:0]       w_src;

  // Divider terminal count, fall-event detection and next slot bit index
  always_comb begin
    w_div_tc      = (r_div_cnt == DIV_W'(HALF - 1));
    w_fall        = en_i && w_div_tc && r_bck;
    w_next_bit    = (r_bit_cnt == BIT_W'(FW - 1)) ? '0 : r_bit_cnt + 1'b1;
    w_frame_start = w_fall && (w_next_bit == '0);
  end

  // Frame word {0, left, pad, 0, right, pad}; at frame start the bit emitted
  // comes from the freshly loaded word so its leading 0 is the delay bit
  always_comb begin
    w_load_word = (FW'(r_buf_left)  << (FW - 1 - DATA_RES))
                | (FW'(r_buf_right) << (FRAME_RES - 1 - DATA_RES));
    if (w_frame_start) begin
      w_src = r_buf_full ? w_load_word : '0;
    end else begin
      w_src = r_shift;
    end
  end

  // Bit clock divider, slot counter and serialiser
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_div_cnt  <= '0;
      r_bck      <= 1'b0;
      r_bit_cnt  <= BIT_W'(FW - 1);
      r_lrck     <= 1'b0;
      r_dat      <= 1'b0;
      r_shift    <= '0;
      r_underrun <= 1'b0;
    end else if (!en_i) begin
      r_div_cnt  <= '0;
      r_bck      <= 1'b0;
      r_bit_cnt  <= BIT_W'(FW - 1);
      r_lrck     <= 1'b0;
      r_dat      <= 1'b0;
      r_shift    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_div_tc) begin
        r_div_cnt <= '0;
        r_bck     <= ~r_bck;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_next_bit;
        r_lrck    <= (w_next_bit >= BIT_W'(FRAME_RES));
        r_dat     <= w_src[FW-1];
        r_shift   <= {w_src[FW-2:0], 1'b0};
        if (w_frame_start && !r_buf_full) begin
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // Single-entry holding buffer; keeps running while the serialiser is disabled.
  // A capture in the same cycle as an empty-buffer load is held for the next frame
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_buf_full  <= 1'b0;
      r_buf_left  <= '0;
      r_buf_right <= '0;
    end else if (valid_i && !r_buf_full) begin
      r_buf_full  <= 1'b1;
      r_buf_left  <= left_i;
      r_buf_right <= right_i;
    end else if (w_frame_start && r_buf_full) begin
      r_buf_full  <= 1'b0;
    end
  end

  assign ready_o    = ~r_buf_full;
  assign bck_o      = r_bck;
  assign lrck_o     = r_lrck;
  assign dat_o      = r_dat;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_i2s_tx_module.sv
// Self-checking bench for i2s_tx_module: cycle-indexed reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_i2s_tx_module;

  localparam int F  = 32;
  localparam int D  = 24;
  localparam int P  = 4;
  localparam int H  = P / 2;
  localparam int WW = 2 * F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en_i = 1'b0;
  logic [D-1:0] left_i = '0;
  logic [D-1:0] right_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_o, bck_o, lrck_o, dat_o, underrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  i2s_tx_module #(.FRAME_RES(F), .DATA_RES(D), .BCK_DIV(P)) dut (
    .clk_i(clk), .rst_i(rst_n), .en_i(en_i), .left_i(left_i), .right_i(right_i),
    .valid_i(valid_i), .ready_o(ready_o), .bck_o(bck_o), .lrck_o(lrck_o),
    .dat_o(dat_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts enabled cycles since restart; every P-th cycle
  // is a fall, fall k carries slot bit (k-1) mod 2F of the current frame word.
  int unsigned   m_t;
  int unsigned   m_k, m_b;
  logic          m_full, m_hs;
  logic [D-1:0]  m_l, m_r;
  logic [WW-1:0] m_word;
  logic          m_bck, m_lrck, m_dat, m_und;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_full = 1'b0; m_l = '0; m_r = '0; m_word = '0;
      m_bck = 1'b0; m_lrck = 1'b0; m_dat = 1'b0; m_und = 1'b0;
    end else begin
      m_hs  = valid_i && !m_full;
      m_und = 1'b0;
      if (!en_i) begin
        m_t = 0; m_bck = 1'b0; m_lrck = 1'b0; m_dat = 1'b0;
      end else begin
        m_t   = m_t + 1;
        m_bck = ((m_t / H) % 2) == 1;
        if (m_t % P == 0) begin
          m_k = m_t / P;
          m_b = (m_k - 1) % WW;
          if (m_b == 0) begin
            if (m_full) begin
              m_word = (WW'(m_l) << (WW - 1 - D)) | (WW'(m_r) << (F - 1 - D));
              m_full = 1'b0;
            end else begin
              m_word = '0;
              m_und  = 1'b1;
            end
          end
          m_lrck = (m_b >= F);
          m_dat  = m_word[WW-1-m_b];
        end
      end
      if (m_hs) begin
        m_full = 1'b1; m_l = left_i; m_r = right_i;
      end
    end
  end

  logic chk_on = 1'b0;

  // Compare every output against the model on each falling clk edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk1("bck", bck_o, m_bck);
      chk1("lrck", lrck_o, m_lrck);
      chk1("dat", dat_o, m_dat);
      chk1("underrun", underrun_o, m_und);
      chk1("ready", ready_o, !m_full);
    end
  end

  // Observation helpers: bits on each BCK fall, handshake and underrun counts
  logic        prev_bck = 1'b0;
  logic [63:0] cap_d = '0, cap_l = '0;
  int          cap_n = 0, cyc_n = 0, und_cnt = 0, und_last = 0, und_gap = 0, acc_cnt = 0;

  always @(negedge clk) begin
    cyc_n++;
    if (!rst_n || !en_i) begin
      cap_n = 0;
    end else if (prev_bck && !bck_o) begin
      cap_d = {cap_d[62:0], dat_o};
      cap_l = {cap_l[62:0], lrck_o};
      cap_n++;
    end
    prev_bck = bck_o;
    if (rst_n && underrun_o) begin
      if (und_cnt > 0) und_gap = cyc_n - und_last;
      und_last = cyc_n;
      und_cnt++;
    end
    if (rst_n && valid_i && ready_o) acc_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    und_cnt = 0;
    acc_cnt = 0;
  endtask

  int unsigned val, seen;

  initial begin
    // Scenario 1: sample ready before first frame start
    en_i = 1'b1; valid_i = 1'b1; left_i = 24'hABCDEF; right_i = 24'h123456;
    #1;
    do_reset();
    chk_on = 1'b1;
    chk1("rst_ready", ready_o, 1'b1);
    chk1("rst_bck", bck_o, 1'b0);
    cyc(1);
    chk1("bck_e1", bck_o, 1'b0);
    chk1("ready_after_acc", ready_o, 1'b0);
    valid_i = 1'b0;
    cyc(1);
    chk1("bck_rise_e2", bck_o, 1'b1);
    cyc(2);
    chk1("bck_fall_e4", bck_o, 1'b0);
    chk1("no_und_first", underrun_o, 1'b0);
    chk1("ready_after_load", ready_o, 1'b1);
    cyc(253);
    chk64("frame0_bits", 64'(cap_n), 64'd64);
    chk64("frame0_dat", cap_d, 64'h55E6F780_091A2B00);
    chk64("frame0_lrck", cap_l, 64'h00000000_FFFFFFFF);
    cyc(256);
    chk64("frame1_und", 64'(und_cnt), 64'd1);
    chk64("frame1_dat", cap_d, 64'h0);

    // Scenario 2: no data at all
    valid_i = 1'b0;
    do_reset();
    cyc(768);
    chk64("idle_und_cnt", 64'(und_cnt), 64'd3);
    chk64("idle_und_gap", 64'(und_gap), 64'd256);
    chk64("idle_dat", cap_d, 64'h0);

    // Scenario 3: valid held high, incrementing payload
    val = 1; seen = 0;
    left_i = D'(val); right_i = D'(val + 100); valid_i = 1'b1;
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      cyc(1);
      if (acc_cnt != int'(seen)) begin
        seen = acc_cnt;
        val++;
        left_i = D'(val); right_i = D'(val + 100);
      end
    end
    chk64("stream_acc", 64'(acc_cnt), 64'd5);
    chk64("stream_und", 64'(und_cnt), 64'd0);
    valid_i = 1'b0;

    // Scenario 4: handshake coincides with empty-buffer frame start
    left_i = 24'h800001; right_i = 24'h7FFFFF;
    do_reset();
    cyc(3);
    valid_i = 1'b1;
    cyc(1);
    chk1("coinc_und", underrun_o, 1'b1);
    chk1("coinc_ready", ready_o, 1'b0);
    valid_i = 1'b0;
    cyc(1);
    chk1("coinc_und_end", underrun_o, 1'b0);
    cyc(508);
    chk64("coinc_bits", 64'(cap_n), 64'd128);
    chk64("coinc_dat", cap_d, 64'h40000080_3FFFFF80);
    chk64("coinc_und_cnt", 64'(und_cnt), 64'd1);

    // Scenario 5: enable dropped at left bit 10, then restart
    left_i = 24'h004000; right_i = 24'hFFFFFF; valid_i = 1'b1;
    do_reset();
    cyc(1);
    left_i = 24'h5A5A5A; right_i = 24'hA5A5A5;
    cyc(4);
    valid_i = 1'b0;
    cyc(39);
    chk1("bit10_lrck", lrck_o, 1'b0);
    chk1("bit10_dat", dat_o, 1'b1);
    en_i = 1'b0;
    cyc(1);
    chk1("dis_bck", bck_o, 1'b0);
    chk1("dis_lrck", lrck_o, 1'b0);
    chk1("dis_dat", dat_o, 1'b0);
    chk1("dis_buf_kept", ready_o, 1'b0);
    cyc(3);
    en_i = 1'b1;
    left_i = 24'h111111; right_i = 24'h222222; valid_i = 1'b1;
    cyc(2);
    chk1("reen_bck_rise", bck_o, 1'b1);
    cyc(2);
    chk1("reen_bck_fall", bck_o, 1'b0);
    chk1("reen_no_und", underrun_o, 1'b0);
    chk1("reen_ready", ready_o, 1'b1);
    cyc(1);
    valid_i = 1'b0;
    chk1("reen_full", ready_o, 1'b0);
    cyc(159);
    chk1("right_slot_lrck", lrck_o, 1'b1);

    // Scenario 6: asynchronous reset mid right slot with buffer full
    rst_n = 1'b0;
    #1;
    chk1("arst_ready", ready_o, 1'b1);
    chk1("arst_bck", bck_o, 1'b0);
    chk1("arst_lrck", lrck_o, 1'b0);
    chk1("arst_dat", dat_o, 1'b0);
    chk1("arst_und", underrun_o, 1'b0);
    cyc(1);

    // Scenario 7: randomized traffic and enable toggling against the model
    en_i = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      valid_i = ($urandom_range(0, 3) == 0);
      left_i  = D'($urandom);
      right_i = D'($urandom);
      if ($urandom_range(0, 399) == 0) en_i = ~en_i;
    end
    en_i = 1'b1;
    cyc(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
